regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with write-through bypass and a per-register busy scoreboard, replacing the fixed 2R1W, 32x32 file in the CPU datapath. Decode reads operands and busy status, then allocates a destination at issue. Writeback retires results through two write ports. The busy bits let the pipeline detect RAW hazards without a separate scoreboard block.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- raddr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  read data, packed the same way
- rbusy  out  NRD  busy flag seen by each read port
- wen0, wen1  in  1  write enables
- waddr0, waddr1  in  ADDR_W  write addresses
- wdata0, wdata1  in  DATA_W  write data
- alloc_en  in  1  mark a destination busy (instruction issue)
- alloc_addr  in  ADDR_W  destination being allocated
- flush  in  1  clear all busy bits (pipeline flush)
- busy_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Register 0 always reads 0 and is never busy. Writes and allocs to address 0 are ignored.
- Write, rising edge: if wenK and waddrK != 0, then rf[waddrK] <= wdataK.
  - If both ports target the same nonzero address, port 1 wins.
- Read, combinational, per port i, in priority order:
  - raddr == 0 gives 0.
  - Else a matching enabled write port 1 gives wdata1.
  - Else a matching enabled write port 0 gives wdata0.
  - Else rf[raddr].
- Busy, rising edge, per address a != 0:
  - flush clears every busy bit and ignores alloc in the same cycle.
  - Else if alloc_en and alloc_addr == a, set the bit. Alloc beats a same-cycle write clear, because a new producer is taking the register.
  - Else if a write targets a, clear the bit.
  - Else hold.
- rbusy[i]:
  - If raddr == 0, rbusy[i] = 0.
  - Else if an enabled write targets raddr this cycle, rbusy[i] = 0. The bypass satisfies the hazard.
  - Else rbusy[i] = busy[raddr].
- busy_cnt: registered population count of the busy vector, updated in the same edge as the busy bits.
- Reset, asserted at any time and regardless of clock: all rf entries = 0, all busy bits = 0, busy_cnt = 0. rdata and rbusy then read 0.

## Timing
- Read latency is 0 cycles, combinational from raddr, waddr, wen and wdata. Written data is visible on the same cycle via bypass, and from the array on the next cycle.
- Alloc is visible on rbusy the cycle after alloc_en.
- Write clears busy at the same edge it updates rf.
- Deasserting resetn takes effect on the next rising edge. Inputs are ignored while resetn = 0.
- No handshakes; every request completes in one cycle.

## Structure
- Shared package regfile_pkg holds:
  - the default values for DATA_W, ADDR_W and NRD;
  - a function popcount(busy vector) used for busy_cnt.
- Sub-module rf_read_port, instantiated NRD times via generate. Each instance takes raddr, both write ports and busy[raddr], and produces rdata and rbusy for one port.
- The top level holds the storage array, the busy vector and the busy_cnt register.

## Test plan
- Reset, then read all 32 addresses on both ports → rdata = 0, rbusy = 0, busy_cnt = 0.
- Write 0xDEADBEEF to r5 on port 0 while raddr0 = 5 in the same cycle → rdata0 = 0xDEADBEEF in that cycle and in every cycle after.
- Same cycle: wen0 writes 0x1 to r7 and wen1 writes 0x2 to r7 → read r7 gives 0x2 in that cycle and after. Any write to r0 → r0 still reads 0.
- Alloc r3 → next cycle rbusy = 1 and busy_cnt = 1. Then in one cycle, write r3 and alloc r3 → r3 stays busy and busy_cnt = 1. Then a write to r3 alone → busy clears and busy_cnt = 0.
- Alloc r1, r2, r4 on successive cycles, then assert flush together with alloc r6 → all busy bits 0 and busy_cnt = 0 on the next cycle.
- Drop resetn mid-stream with r9 = 0x55 and r9 busy → rdata for r9 goes to 0 and rbusy to 0 without a clock edge. busy_cnt = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: default widths for regfile_sb and the popcount helper used for busy_cnt
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF = 2;
  localparam int MAX_REGS = 256;
  function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_REGS; i++) n += 32'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port; raddr/write ports/busy/rf_data in, bypassed rdata and hazard-aware rbusy out
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              busy,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);
  logic zero, hit0, hit1;
  always_comb begin
    zero = raddr == '0;
    hit0 = wen0 && waddr0 == raddr;
    hit1 = wen1 && waddr1 == raddr;
    rdata = zero ? '0 : hit1 ? wdata1 : hit0 ? wdata0 : rf_data;
    rbusy = !zero && !hit0 && !hit1 && busy;
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: NRD-read 2-write register file with bypass and busy scoreboard; raddr/rdata/rbusy, wen/waddr/wdata x2, alloc, flush, busy_cnt
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD = NRD_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  wen0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  wen1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  input  logic                  flush,
  output logic [ADDR_W:0]       busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0] busy_cnt_q, busy_cnt_d;
  logic [MAX_REGS-1:0] pop_in;
  logic we0, we1;
  always_comb begin
    we0 = resetn && wen0 && waddr0 != '0;
    we1 = resetn && wen1 && waddr1 != '0;
    rf_d = rf_q;
    if (we0) rf_d[waddr0] = wdata0;
    if (we1) rf_d[waddr1] = wdata1;
    busy_d = '0;
    for (int a = 1; a < DEPTH; a++)
      busy_d[a] = flush ? 1'b0
                : (alloc_en && alloc_addr == ADDR_W'(a)) ? 1'b1
                : ((we0 && waddr0 == ADDR_W'(a)) || (we1 && waddr1 == ADDR_W'(a))) ? 1'b0
                : busy_q[a];
    pop_in = '0;
    pop_in[DEPTH-1:0] = busy_d;
    busy_cnt_d = (ADDR_W+1)'(popcount(pop_in));
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rf_q <= '{default: '0};
      busy_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      rf_q <= rf_d;
      busy_q <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  assign busy_cnt = busy_cnt_q;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[i*ADDR_W +: ADDR_W];
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp (
      .raddr(ra),
      .wen0(we0),
      .waddr0(waddr0),
      .wdata0(wdata0),
      .wen1(we1),
      .waddr1(waddr1),
      .wdata1(wdata1),
      .busy(busy_q[ra]),
      .rf_data(rf_q[ra]),
      .rdata(rdata[i*DATA_W +: DATA_W]),
      .rbusy(rbusy[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb with directed vectors
module tb_regfile_sb;
  logic clk = 0;
  logic resetn = 0;
  logic [9:0] raddr = '0;
  logic [63:0] rdata;
  logic [1:0] rbusy;
  logic wen0 = 0, wen1 = 0, alloc_en = 0, flush = 0;
  logic [4:0] waddr0 = '0, waddr1 = '0, alloc_addr = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [5:0] busy_cnt;
  int checks = 0;
  int failures = 0;
  bit done = 0;
  typedef struct {
    string name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0] rb;
    logic [5:0] cnt;
  } exp_t;
  exp_t q[$];
  regfile_sb dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .busy_cnt(busy_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wen0 = 0;
    wen1 = 0;
    alloc_en = 0;
    flush = 0;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask
  task automatic exp(input string n, input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] rb, input logic [5:0] cnt);
    exp_t e;
    e.name = n;
    e.d0 = d0;
    e.d1 = d1;
    e.rb = rb;
    e.cnt = cnt;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 4;
      if (rdata[31:0] !== e.d0) begin
        failures++;
        $display("FAIL %s rdata0 got=%h want=%h", e.name, rdata[31:0], e.d0);
      end
      if (rdata[63:32] !== e.d1) begin
        failures++;
        $display("FAIL %s rdata1 got=%h want=%h", e.name, rdata[63:32], e.d1);
      end
      if (rbusy !== e.rb) begin
        failures++;
        $display("FAIL %s rbusy got=%b want=%b", e.name, rbusy, e.rb);
      end
      if (busy_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s busy_cnt got=%0d want=%0d", e.name, busy_cnt, e.cnt);
      end
    end
  end
  initial begin
    tick(); rd(5, 9); exp("in_reset", 0, 0, 2'b00, 0);
    tick(); resetn = 1;
    for (int a = 0; a < 32; a++) begin
      tick(); rd(5'(a), 5'(31 - a)); exp("rd_all", 0, 0, 2'b00, 0);
    end
    tick(); wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; rd(5, 0);
    exp("bypass_r5", 32'hDEADBEEF, 0, 2'b00, 0);
    tick(); idle(); rd(5, 5); exp("array_r5", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    tick(); exp("array_r5_again", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    tick(); wen0 = 1; waddr0 = 7; wdata0 = 1; wen1 = 1; waddr1 = 7; wdata1 = 2; rd(7, 5);
    exp("p1_wins_bypass", 2, 32'hDEADBEEF, 2'b00, 0);
    tick(); wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFF; wen1 = 1; waddr1 = 0; wdata1 = 32'hAAAA; rd(7, 0);
    exp("p1_wins_array_w_r0", 2, 0, 2'b00, 0);
    tick(); idle(); rd(0, 7); exp("r0_zero", 0, 2, 2'b00, 0);
    tick(); alloc_en = 1; alloc_addr = 3; rd(3, 3); exp("alloc_r3_same", 0, 0, 2'b00, 0);
    tick(); idle(); exp("alloc_r3_next", 0, 0, 2'b11, 1);
    tick(); wen0 = 1; waddr0 = 3; wdata0 = 32'h33; alloc_en = 1; alloc_addr = 3;
    exp("wr_alloc_r3", 32'h33, 32'h33, 2'b00, 1);
    tick(); idle(); exp("r3_still_busy", 32'h33, 32'h33, 2'b11, 1);
    tick(); wen1 = 1; waddr1 = 3; wdata1 = 32'h44; rd(3, 2);
    exp("wr_r3_clear", 32'h44, 0, 2'b00, 1);
    tick(); idle(); rd(3, 3); exp("r3_cleared", 32'h44, 32'h44, 2'b00, 0);
    tick(); alloc_en = 1; alloc_addr = 1; rd(1, 2); exp("alloc_r1", 0, 0, 2'b00, 0);
    tick(); alloc_addr = 2; exp("alloc_r2", 0, 0, 2'b01, 1);
    tick(); alloc_addr = 4; exp("alloc_r4", 0, 0, 2'b11, 2);
    tick(); flush = 1; alloc_addr = 6; rd(4, 6); exp("flush_alloc_r6", 0, 0, 2'b01, 3);
    tick(); idle(); exp("after_flush_46", 0, 0, 2'b00, 0);
    tick(); rd(1, 2); exp("after_flush_12", 0, 0, 2'b00, 0);
    tick(); wen0 = 1; waddr0 = 9; wdata0 = 32'h55; alloc_en = 1; alloc_addr = 9; rd(9, 9);
    exp("r9_wr_alloc", 32'h55, 32'h55, 2'b00, 0);
    tick(); idle(); exp("r9_busy", 32'h55, 32'h55, 2'b11, 1);
    tick(); resetn = 0; exp("async_reset", 0, 0, 2'b00, 0);
    tick(); wen0 = 1; waddr0 = 9; wdata0 = 32'h77; alloc_en = 1; alloc_addr = 9;
    exp("ignored_in_reset", 0, 0, 2'b00, 0);
    tick(); idle(); resetn = 1; exp("after_reset", 0, 0, 2'b00, 0);
    tick();
    repeat (4) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
